silife_gen_scheduler: RTL and testbench
=======================================

Name: silife_gen_scheduler

Overview:
Sequences Game-of-Life generation updates against the LED matrix scan.
- Counts completed display frames reported by the scanner and issues a start pulse to the life engine every N frames, or on a single-step request.
- Waits for the engine to finish, then issues a front/back buffer swap aligned to a frame boundary, so the scanner never displays a half-updated grid.
- Sits between silife_scan (frame source) and the life engine / cell double-buffer.

Parameters:
PERIOD_WIDTH, 16, width of the period input and of the internal frame counter.
GEN_WIDTH, 16, width of the generation counter.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  free-run mode; level-sensitive
step  input  1  single-step request; one-cycle pulse
period  input  PERIOD_WIDTH  frames per generation; 0 is treated as 1
frame_done  input  1  one-cycle pulse from the scanner at the end of row 7
engine_start  output  1  one-cycle pulse that starts one engine generation
engine_done  input  1  one-cycle pulse when the engine has written the back buffer
buf_swap  output  1  one-cycle pulse that swaps the front and back cell buffers
generation  output  GEN_WIDTH  count of completed generations
busy  output  1  high while in START, RUN or SWAP_WAIT
overrun  output  1  sticky flag: a generation took longer than period frames in free-run mode
engine_timeout  output  1  sticky watchdog flag (see Optional Feature)

Behaviour:
- All outputs are registered.
- Reset: state=IDLE; frame_cnt=0; generation=0; engine_start=0; buf_swap=0; busy=0; overrun=0; engine_timeout=0. Reset applied in any state, including RUN, returns to IDLE on the next edge with no pulses issued.
- period_eff = (period==0) ? 1 : period. Sampled every cycle.
- State IDLE:
  - step=1 goes to START. step wins over enable in the same cycle.
  - Otherwise enable=1 goes to COUNT with frame_cnt=0.
- State COUNT:
  - On frame_done, frame_cnt increments. When frame_cnt+1 >= period_eff, go to START and clear frame_cnt.
  - step=1 goes to START immediately and clears frame_cnt.
  - enable=0 (with no step) goes to IDLE and clears frame_cnt.
- State START: engine_start=1 for exactly this cycle; go to RUN. engine_done sampled in START is ignored.
- State RUN:
  - Wait for engine_done, then go to SWAP_WAIT.
  - If the generation was started from free-run (enable=1 when START was entered), frame_done pulses are counted. When the count reaches period_eff before the swap, set overrun=1 (sticky).
- State SWAP_WAIT:
  - Wait for frame_done. In the cycle after frame_done is sampled, buf_swap=1 for one cycle and generation increments (wraps from all-ones to 0).
  - Then go to COUNT with frame_cnt=0 if enable=1, else IDLE.
  - The swap frame is not counted toward the next period.
  - Overrun counting continues here as in RUN.
- Single-step generations never set overrun.
- step pulses in START, RUN or SWAP_WAIT are dropped, not queued.
- frame_done and engine_done arriving in the same cycle in RUN: go to SWAP_WAIT; that frame_done is not used for the swap (the next one is).
- Latency: frame_done that completes the period → engine_start 1 cycle later. engine_done → earliest buf_swap 2 cycles later (one cycle to reach SWAP_WAIT, plus the cycle after a frame_done sampled in SWAP_WAIT).
- busy goes high the cycle engine_start is asserted and low the cycle after buf_swap.

Optional Feature:
Macro: SILIFE_GEN_WATCHDOG_EN.
- Defined: a 10-bit cycle counter runs in RUN and clears on entering RUN. If it reaches 1023 without engine_done, go to IDLE, set engine_timeout=1 (sticky until reset), skip buf_swap, and leave generation unchanged.
- Undefined: the engine_timeout port remains but is tied to 0; RUN waits indefinitely.

Test Plan:
- Reset, then enable=1, period=3, engine_done 4 cycles after each start, frame_done every 40 cycles → engine_start one cycle after the 3rd frame_done; buf_swap one cycle after the next sampled frame_done; generation=1; overrun=0.
- enable=0, step pulse in IDLE → engine_start next cycle; after engine_done and frame_done, exactly one buf_swap; generation=1; returns to IDLE; a second step during RUN is dropped (generation stays 1).
- period=0, enable=1 → engine_start after every frame_done in COUNT (behaves as period=1).
- enable=1, period=2, engine_done held off for 3 frame_done pulses → overrun=1 and stays 1 across later generations until reset.
- Assert reset for one cycle while in RUN → next cycle all outputs are 0 and state is IDLE; a late engine_done produces no buf_swap.
- With SILIFE_GEN_WATCHDOG_EN defined and engine_done never asserted → engine_timeout=1 about 1023 cycles after engine_start, state IDLE, generation unchanged.

Source files
------------

// File: rtl/silife_gen_scheduler.sv
// Paces Game-of-Life generations against the LED scan and swaps cell buffers on frame boundaries.
// Define SILIFE_GEN_WATCHDOG_EN to abort engine runs that never report engine_done.
module silife_gen_scheduler #(
    parameter int PERIOD_WIDTH = 16,
    parameter int GEN_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    step,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    frame_done,
    output logic                    engine_start,
    input  logic                    engine_done,
    output logic                    buf_swap,
    output logic [GEN_WIDTH-1:0]    generation,
    output logic                    busy,
    output logic                    overrun,
    output logic                    engine_timeout
);
    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        START,
        RUN,
        SWAP_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    logic [PERIOD_WIDTH-1:0] ov_cnt_q, ov_cnt_d;
    logic                    free_run_q, free_run_d;
    logic [GEN_WIDTH-1:0]    gen_q, gen_d;
    logic                    start_q, start_d;
    logic                    swap_q, swap_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
`ifdef SILIFE_GEN_WATCHDOG_EN
    logic [9:0]              wd_cnt_q, wd_cnt_d;
    logic                    timeout_q, timeout_d;
`endif

    logic [PERIOD_WIDTH-1:0] period_eff;
    logic [PERIOD_WIDTH:0]   frame_cnt_inc;
    logic [PERIOD_WIDTH:0]   ov_cnt_inc;

    assign period_eff    = (period == '0) ? PERIOD_WIDTH'(1) : period;
    assign frame_cnt_inc = {1'b0, frame_cnt_q} + (PERIOD_WIDTH+1)'(1);
    assign ov_cnt_inc    = {1'b0, ov_cnt_q} + (PERIOD_WIDTH+1)'(1);

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        ov_cnt_d    = ov_cnt_q;
        free_run_d  = free_run_q;
        gen_d       = gen_q;
        swap_d      = 1'b0;
        overrun_d   = overrun_q;
`ifdef SILIFE_GEN_WATCHDOG_EN
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;
`endif

        // Frames elapsed since a free-run start, including the one that triggers the swap.
        if ((state_q == RUN || state_q == SWAP_WAIT) && free_run_q && frame_done) begin
            ov_cnt_d = ov_cnt_inc[PERIOD_WIDTH-1:0];
            if (ov_cnt_inc >= {1'b0, period_eff}) overrun_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (step) begin
                    state_d    = START;
                    free_run_d = 1'b0;
                end else if (enable) begin
                    state_d     = COUNT;
                    frame_cnt_d = '0;
                end
            end
            COUNT: begin
                if (step) begin
                    state_d     = START;
                    frame_cnt_d = '0;
                    free_run_d  = 1'b0;
                end else if (!enable) begin
                    state_d     = IDLE;
                    frame_cnt_d = '0;
                end else if (frame_done) begin
                    if (frame_cnt_inc >= {1'b0, period_eff}) begin
                        state_d     = START;
                        frame_cnt_d = '0;
                        free_run_d  = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_inc[PERIOD_WIDTH-1:0];
                    end
                end
            end
            START: begin
                state_d  = RUN;
                ov_cnt_d = '0;
`ifdef SILIFE_GEN_WATCHDOG_EN
                wd_cnt_d = '0;
`endif
            end
            RUN: begin
                if (engine_done) begin
                    state_d = SWAP_WAIT;
`ifdef SILIFE_GEN_WATCHDOG_EN
                end else if (wd_cnt_q == '1) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 10'd1;
`endif
                end
            end
            SWAP_WAIT: begin
                if (frame_done) begin
                    swap_d      = 1'b1;
                    gen_d       = gen_q + GEN_WIDTH'(1);
                    state_d     = enable ? COUNT : IDLE;
                    frame_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        start_d = (state_d == START);
        busy_d  = (state_d == START) || (state_d == RUN) || (state_d == SWAP_WAIT) || swap_d;
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so all of them update together.
        if (reset) begin
            state_q     <= IDLE;
            frame_cnt_q <= '0;
            ov_cnt_q    <= '0;
            free_run_q  <= 1'b0;
            gen_q       <= '0;
            start_q     <= 1'b0;
            swap_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef SILIFE_GEN_WATCHDOG_EN
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            ov_cnt_q    <= ov_cnt_d;
            free_run_q  <= free_run_d;
            gen_q       <= gen_d;
            start_q     <= start_d;
            swap_q      <= swap_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
`ifdef SILIFE_GEN_WATCHDOG_EN
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign engine_start = start_q;
    assign buf_swap     = swap_q;
    assign generation   = gen_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;
`ifdef SILIFE_GEN_WATCHDOG_EN
    assign engine_timeout = timeout_q;
`else
    assign engine_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_silife_gen_scheduler.sv
// Bench for silife_gen_scheduler: hand-built vector table, directed scenarios and random
// stimulus, with every cycle compared against an event-level model of the scheduler.
module tb_silife_gen_scheduler;
    localparam int PW = 16;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          step = 1'b0;
    logic [PW-1:0] period = '0;
    logic          frame_done = 1'b0;
    logic          engine_done = 1'b0;
    logic          engine_start, buf_swap, busy, overrun, engine_timeout;
    logic [GW-1:0] generation;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    silife_gen_scheduler #(.PERIOD_WIDTH(PW), .GEN_WIDTH(GW)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .step           (step),
        .period         (period),
        .frame_done     (frame_done),
        .engine_start   (engine_start),
        .engine_done    (engine_done),
        .buf_swap       (buf_swap),
        .generation     (generation),
        .busy           (busy),
        .overrun        (overrun),
        .engine_timeout (engine_timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks whether a generation is in flight, whether the engine has
    // reported completion, and how many frames have passed, then derives the pulses.
    bit            m_active, m_launch_cycle, m_engine_finished, m_free, m_counting;
    int            m_frames, m_gen_frames;
    logic [GW-1:0] m_gen;
    bit            m_overrun, m_timeout;
    bit            e_start, e_swap, e_busy;
`ifdef SILIFE_GEN_WATCHDOG_EN
    int            m_wait;
`endif

    task automatic launch(input bit free);
        m_active          = 1'b1;
        m_launch_cycle    = 1'b1;
        m_engine_finished = 1'b0;
        m_free            = free;
        m_gen_frames      = 0;
        m_counting        = 1'b0;
        m_frames          = 0;
        e_start           = 1'b1;
`ifdef SILIFE_GEN_WATCHDOG_EN
        m_wait            = 0;
`endif
    endtask

    task automatic model_step(input bit rst, en, st, input logic [PW-1:0] per, input bit fd, ed);
        int peff;
        peff    = (per == '0) ? 1 : int'(per);
        e_start = 1'b0;
        e_swap  = 1'b0;
        if (rst) begin
            m_active = 0; m_launch_cycle = 0; m_engine_finished = 0; m_free = 0;
            m_counting = 0; m_frames = 0; m_gen_frames = 0; m_gen = '0;
            m_overrun = 0; m_timeout = 0;
        end else if (!m_active) begin
            if (st) launch(1'b0);
            else if (!m_counting) begin
                if (en) begin m_counting = 1'b1; m_frames = 0; end
            end else if (!en) begin
                m_counting = 1'b0; m_frames = 0;
            end else if (fd) begin
                m_frames++;
                if (m_frames >= peff) launch(1'b1);
            end
        end else if (m_launch_cycle) begin
            m_launch_cycle = 1'b0;
        end else begin
            if (m_free && fd) begin
                m_gen_frames++;
                if (m_gen_frames >= peff) m_overrun = 1'b1;
            end
            if (!m_engine_finished) begin
                if (ed) m_engine_finished = 1'b1;
`ifdef SILIFE_GEN_WATCHDOG_EN
                else if (m_wait == 1023) begin
                    m_active = 1'b0; m_counting = 1'b0; m_timeout = 1'b1;
                end else m_wait++;
`endif
            end else if (fd) begin
                e_swap = 1'b1; m_gen = m_gen + 1'b1;
                m_active = 1'b0; m_counting = en; m_frames = 0;
            end
        end
        e_busy = m_active || e_swap;
    endtask

    // One clock: drive at negedge, sample #1 after the rising edge, compare with the model.
    task automatic tick(input bit rst, en, st, input logic [PW-1:0] per, input bit fd, ed);
        @(negedge clk);
        reset = rst; enable = en; step = st; period = per; frame_done = fd; engine_done = ed;
        @(posedge clk);
        #1;
        model_step(rst, en, st, per, fd, ed);
        check("model", {11'd0, engine_start, buf_swap, busy, overrun, engine_timeout, generation},
              {11'd0, e_start, e_swap, e_busy, m_overrun, m_timeout, m_gen});
    endtask

    typedef struct {
        bit rst, en, st, fd, ed;
        bit x_start, x_swap, x_busy;
        int x_gen;
    } vec_t;
    vec_t vecs[16];

    initial begin
        int s1, s2, w1, n_starts, n_swaps, swap_seen;
        bit r_en;
        logic [PW-1:0] r_per;

        // Single-step walk: dropped steps, engine_done in START, coincident frame/engine done.
        vecs[0]  = '{1,0,0,0,0, 0,0,0, 0};
        vecs[1]  = '{0,0,1,0,0, 1,0,1, 0};
        vecs[2]  = '{0,0,0,0,1, 0,0,1, 0};
        vecs[3]  = '{0,0,0,1,0, 0,0,1, 0};
        vecs[4]  = '{0,0,1,0,0, 0,0,1, 0};
        vecs[5]  = '{0,0,0,0,1, 0,0,1, 0};
        vecs[6]  = '{0,0,0,0,0, 0,0,1, 0};
        vecs[7]  = '{0,0,1,1,0, 0,1,1, 1};
        vecs[8]  = '{0,0,0,0,0, 0,0,0, 1};
        vecs[9]  = '{0,0,0,0,0, 0,0,0, 1};
        vecs[10] = '{0,0,1,0,0, 1,0,1, 1};
        vecs[11] = '{0,0,0,0,0, 0,0,1, 1};
        vecs[12] = '{0,0,0,1,1, 0,0,1, 1};
        vecs[13] = '{0,0,0,0,0, 0,0,1, 1};
        vecs[14] = '{0,0,0,1,0, 0,1,1, 2};
        vecs[15] = '{0,0,0,0,0, 0,0,0, 2};
        for (int i = 0; i < 16; i++) begin
            tick(vecs[i].rst, vecs[i].en, vecs[i].st, PW'(3), vecs[i].fd, vecs[i].ed);
            check($sformatf("vec%0d start", i), 32'(engine_start), 32'(vecs[i].x_start));
            check($sformatf("vec%0d swap", i), 32'(buf_swap), 32'(vecs[i].x_swap));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].x_busy));
            check($sformatf("vec%0d gen", i), 32'(generation), vecs[i].x_gen);
        end
        check("vec overrun", 32'(overrun), 32'd0);

        // Free run, period 3, frames every 40 cycles, engine done 4 cycles after start.
        tick(1, 0, 0, PW'(3), 0, 0);
        s1 = -1; s2 = -1; w1 = -1;
        for (int c = 0; c < 300; c++) begin
            tick(0, 1, 0, PW'(3), c % 40 == 39, c == 123 || c == 283);
            if (engine_start) begin
                if (s1 < 0) s1 = c;
                else if (s2 < 0) s2 = c;
            end
            if (buf_swap && w1 < 0) w1 = c;
            if (c == 159) begin
                check("p3 generation", 32'(generation), 32'd1);
                check("p3 overrun", 32'(overrun), 32'd0);
            end
        end
        check("p3 first start", s1, 119);
        check("p3 first swap", w1, 159);
        check("p3 second start", s2, 279);

        // period 0 behaves as 1: a start follows every counted frame.
        tick(1, 0, 0, PW'(0), 0, 0);
        n_starts = 0; n_swaps = 0;
        for (int c = 0; c < 100; c++) begin
            tick(0, 1, 0, PW'(0), c % 10 == 9, c % 20 == 11);
            if (engine_start) begin
                n_starts++;
                check("p0 start on frame", c % 10, 9);
            end
            if (buf_swap) n_swaps++;
        end
        check("p0 starts", n_starts, 5);
        check("p0 swaps", n_swaps, 5);

        // Overrun with period 2; sticky across later generations.
        tick(1, 0, 0, PW'(2), 0, 0);
        for (int c = 0; c < 130; c++) begin
            tick(0, 1, 0, PW'(2), c % 10 == 9, c == 52 || c == 82);
            if (c == 38) check("ovr before", 32'(overrun), 32'd0);
            if (c == 39) check("ovr set", 32'(overrun), 32'd1);
        end
        check("ovr sticky", 32'(overrun), 32'd1);
        check("ovr generation", 32'(generation), 32'd2);
        check("ovr in run busy", 32'(busy), 32'd1);

        // Reset while in RUN, then a late engine_done must not swap.
        tick(1, 1, 0, PW'(2), 0, 0);
        check("rst outputs", {27'd0, engine_start, buf_swap, busy, overrun, engine_timeout}, 32'd0);
        check("rst generation", 32'(generation), 32'd0);
        swap_seen = 0;
        tick(0, 0, 0, PW'(2), 0, 1);
        if (buf_swap) swap_seen++;
        for (int c = 0; c < 3; c++) begin
            tick(0, 0, 0, PW'(2), 1, 0);
            if (buf_swap) swap_seen++;
        end
        check("rst late swap", swap_seen, 0);
        check("rst idle busy", 32'(busy), 32'd0);

`ifdef SILIFE_GEN_WATCHDOG_EN
        // Engine never finishes: watchdog returns to IDLE without a swap.
        tick(1, 0, 0, PW'(2), 0, 0);
        tick(0, 0, 1, PW'(2), 0, 0);
        s1 = -1;
        for (int c = 1; c < 1100; c++) begin
            tick(0, 0, 0, PW'(2), c % 50 == 0, 0);
            if (engine_timeout && s1 < 0) s1 = c;
        end
        check("wd latency", s1, 1025);
        check("wd flag", 32'(engine_timeout), 32'd1);
        check("wd busy", 32'(busy), 32'd0);
        check("wd generation", 32'(generation), 32'd0);
`else
        check("timeout tied low", 32'(engine_timeout), 32'd0);
`endif

        // Random traffic against the model.
        tick(1, 0, 0, PW'(2), 0, 0);
        r_en  = 1'b1;
        r_per = PW'(2);
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) == 0) r_en = ~r_en;
            if ($urandom_range(0, 199) == 0) r_per = PW'($urandom_range(0, 4));
            tick($urandom_range(0, 499) == 0, r_en, $urandom_range(0, 39) == 0, r_per,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
